// File: rtl/mem_burst_ctrl_if.sv
// Host request/response and RAM-side bus of the burst controller.
// master = requester plus RAM environment, slave = controller.
interface mem_burst_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ack;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        output req, we, addr, len, wdata, ram_data_out,
        input  wdata_ack, rdata, rdata_valid, busy, done,
               ram_read, ram_write, ram_address, ram_data_in
    );

    modport slave (
        input  req, we, addr, len, wdata, ram_data_out,
        output wdata_ack, rdata, rdata_valid, busy, done,
               ram_read, ram_write, ram_address, ram_data_in
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller for a single-cycle-latency synchronous RAM.
// Every output is a flop; the FSM and the read-return pipeline share one always_ff.
module mem_burst_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_LEN = 8
) (
    input logic            clock,
    input logic            clear_n,
    mem_burst_ctrl_if.slave bus
);
    localparam int unsigned LEN_CAP = (MAX_LEN == 0) ? 1 : ((MAX_LEN > 15) ? 15 : MAX_LEN);
    localparam logic [3:0]  MAX_L   = 4'(LEN_CAP);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DRAIN, DONE} state_t;

    state_t     state;
    logic [3:0] remain;
    logic [3:0] eff_len;
    logic       drain_last;
    logic       rd_inflight;

    always_comb begin
        eff_len = bus.len;
        if (bus.len == '0)
            eff_len = 4'd1;
        else if (bus.len > MAX_L)
            eff_len = MAX_L;
    end

    // The last read word reaches rdata two cycles after its issue, so DRAIN
    // holds for that tail before DONE; writes go straight to DONE.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state           <= IDLE;
            remain          <= '0;
            drain_last      <= 1'b0;
            rd_inflight     <= 1'b0;
            bus.wdata_ack   <= 1'b0;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.ram_read    <= 1'b0;
            bus.ram_write   <= 1'b0;
            bus.ram_address <= '0;
            bus.ram_data_in <= '0;
        end else begin
            rd_inflight     <= bus.ram_read;
            bus.rdata_valid <= rd_inflight;
            if (rd_inflight)
                bus.rdata <= DATA_W'(bus.ram_data_out);
            bus.done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req) begin
                        bus.busy        <= 1'b1;
                        bus.ram_address <= bus.addr;
                        remain          <= eff_len - 4'd1;
                        if (bus.we) begin
                            state           <= WRITE;
                            bus.ram_write   <= 1'b1;
                            bus.ram_data_in <= bus.wdata;
                            bus.wdata_ack   <= (eff_len > 4'd1);
                        end else begin
                            state        <= READ;
                            bus.ram_read <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (remain != '0) begin
                        bus.ram_address <= bus.ram_address + ADDR_W'(1);
                        remain          <= remain - 4'd1;
                    end else begin
                        bus.ram_read <= 1'b0;
                        drain_last   <= 1'b0;
                        state        <= DRAIN;
                    end
                end
                WRITE: begin
                    if (remain != '0) begin
                        bus.ram_address <= bus.ram_address + ADDR_W'(1);
                        bus.ram_data_in <= bus.wdata;
                        bus.wdata_ack   <= (remain > 4'd1);
                        remain          <= remain - 4'd1;
                    end else begin
                        bus.ram_write <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        drain_last <= 1'b1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: table of bursts checked cycle by cycle
// against a RAM model and a shadow copy, plus reset corner sequences.
module tb_mem_burst_ctrl;
    logic clock;
    logic clear_n;

    mem_burst_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    mem_burst_ctrl #(.ADDR_W(9), .DATA_W(32), .MAX_LEN(8)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [31:0] mem    [0:511] = '{default: 32'h0};
    logic [31:0] shadow [0:511] = '{default: 32'h0};
    logic [31:0] ram_q = 32'h0;

    always @(posedge clock) begin
        if (bus.ram_write) mem[bus.ram_address] <= bus.ram_data_in;
        if (bus.ram_read)  ram_q <= mem[bus.ram_address];
    end
    assign bus.ram_data_out = ram_q;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] seed, input int unsigned k);
        return seed + 32'(k) * 32'h1000_0001;
    endfunction

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [3:0]  len;
        logic [31:0] seed;
        int unsigned n;
        int unsigned done_cyc;
        logic [31:0] first;
        int unsigned poke;
    } vec_t;

    vec_t vecs [11];

    task automatic check_all_zero(input string tag);
        chk({tag, "_wdata_ack"},   32'(bus.wdata_ack),   32'h0);
        chk({tag, "_rdata"},       bus.rdata,            32'h0);
        chk({tag, "_rdata_valid"}, 32'(bus.rdata_valid), 32'h0);
        chk({tag, "_busy"},        32'(bus.busy),        32'h0);
        chk({tag, "_done"},        32'(bus.done),        32'h0);
        chk({tag, "_ram_read"},    32'(bus.ram_read),    32'h0);
        chk({tag, "_ram_write"},   32'(bus.ram_write),   32'h0);
        chk({tag, "_ram_address"}, 32'(bus.ram_address), 32'h0);
        chk({tag, "_ram_data_in"}, bus.ram_data_in,      32'h0);
    endtask

    // Entered and left in a cycle slot, 1 time unit after a rising edge.
    task automatic run_vec(input vec_t v);
        logic [8:0]  a;
        logic        in_burst;
        logic        valid_exp;
        int unsigned nvalid;
        int unsigned ndone;
        nvalid = 0;
        ndone  = 0;
        bus.req   = 1'b1;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.len   = v.len;
        bus.wdata = word(v.seed, 0);
        if (v.we)
            for (int unsigned k = 0; k < v.n; k++) begin
                a = v.addr + 9'(k);
                shadow[a] = word(v.seed, k);
            end
        @(posedge clock);
        for (int unsigned c = 1; c <= v.done_cyc + 1; c++) begin
            #1;
            bus.req   = (c == v.poke);
            bus.we    = 1'b1;
            bus.wdata = word(v.seed, c);
            in_burst  = (c <= v.n);
            a         = v.addr + 9'(c - 1);
            if (v.we) begin
                chk("wr_strobe", 32'(bus.ram_write), 32'(in_burst));
                chk("wr_no_read", 32'(bus.ram_read), 32'h0);
                if (in_burst) begin
                    chk("wr_address", 32'(bus.ram_address), 32'(a));
                    chk("wr_data", bus.ram_data_in, word(v.seed, c - 1));
                    chk("wdata_ack", 32'(bus.wdata_ack), 32'(c < v.n));
                end
            end else begin
                chk("rd_strobe", 32'(bus.ram_read), 32'(in_burst));
                chk("rd_no_write", 32'(bus.ram_write), 32'h0);
                if (in_burst)
                    chk("rd_address", 32'(bus.ram_address), 32'(a));
                valid_exp = (c >= 3) && (c <= v.n + 2);
                chk("rdata_valid", 32'(bus.rdata_valid), 32'(valid_exp));
                if (valid_exp) begin
                    a = v.addr + 9'(c - 3);
                    chk("rdata", bus.rdata, shadow[a]);
                end
                if (c == 3)
                    chk("rdata_first", bus.rdata, v.first);
            end
            chk("done", 32'(bus.done), 32'(c == v.done_cyc));
            chk("busy", 32'(bus.busy), 32'(c <= v.done_cyc));
            nvalid += 32'(bus.rdata_valid);
            ndone  += 32'(bus.done);
            if (c <= v.done_cyc)
                @(posedge clock);
        end
        if (!v.we)
            chk("valid_count", nvalid, v.n);
        chk("done_count", ndone, 32'd1);
    endtask

    initial begin
        logic [31:0] s;
        vecs[0]  = '{1'b1, 9'h005, 4'd1,  32'hDEADBEEF, 1, 2,  32'h0,        0};
        vecs[1]  = '{1'b0, 9'h005, 4'd1,  32'h0,        1, 4,  32'hDEADBEEF, 0};
        vecs[2]  = '{1'b1, 9'h1FE, 4'd4,  32'hA0000000, 4, 5,  32'h0,        0};
        vecs[3]  = '{1'b0, 9'h1FE, 4'd4,  32'h0,        4, 7,  32'hA0000000, 0};
        vecs[4]  = '{1'b1, 9'h040, 4'd0,  32'h12345678, 1, 2,  32'h0,        0};
        vecs[5]  = '{1'b1, 9'h080, 4'd12, 32'h55550000, 8, 9,  32'h0,        0};
        vecs[6]  = '{1'b0, 9'h080, 4'd12, 32'h0,        8, 11, 32'h55550000, 0};
        vecs[7]  = '{1'b0, 9'h040, 4'd0,  32'h0,        1, 4,  32'h12345678, 0};
        vecs[8]  = '{1'b1, 9'h1FC, 4'd8,  32'h01000000, 8, 9,  32'h0,        0};
        vecs[9]  = '{1'b0, 9'h1FF, 4'd3,  32'h0,        3, 6,  32'h31000003, 0};
        vecs[10] = '{1'b0, 9'h080, 4'd8,  32'h0,        8, 11, 32'h55550000, 2};

        clear_n   = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.len   = '0;
        bus.wdata = '0;
        #3;
        check_all_zero("por");
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1;

        for (int unsigned i = 0; i < 11; i++)
            run_vec(vecs[i]);

        // Abort a 6-word write partway through cycle 3.
        s = 32'h77770000;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 9'h100;
        bus.len   = 4'd6;
        bus.wdata = word(s, 0);
        @(posedge clock);
        #1;
        bus.req   = 1'b0;
        bus.wdata = word(s, 1);
        chk("rst_wr_c1", 32'(bus.ram_write), 32'h1);
        @(posedge clock);
        #1;
        bus.wdata = word(s, 2);
        @(posedge clock);
        #1;
        chk("rst_wr_c3", 32'(bus.ram_write), 32'h1);
        chk("rst_addr_c3", 32'(bus.ram_address), 32'h102);
        #2;
        clear_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk("rst_no_done", 32'(bus.done), 32'h0);
            chk("rst_no_write", 32'(bus.ram_write), 32'h0);
        end
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_mem_100", mem[9'h100], word(s, 0));
        chk("rst_mem_101", mem[9'h101], word(s, 1));
        for (int unsigned k = 2; k < 6; k++)
            chk("rst_mem_untouched", mem[9'h100 + 9'(k)], 32'h0);
        shadow[9'h100] = word(s, 0);
        shadow[9'h101] = word(s, 1);

        run_vec('{1'b0, 9'h101, 4'd1, 32'h0, 1, 4, 32'h87770001, 0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
